// File: rtl/bootrom_port_arb_if.sv
// Bootrom port-B sharing bus: core read port, byte loader port and the ROM port-B pins.
// No storage; pure signal bundle.
// The slave modport is the arbiter; the master modport is the requesters plus the ROM.
interface bootrom_port_arb_if #(
    parameter int ADDR_W = 16
);
    logic              d_req_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [31:0]       d_rdata_o;
    logic              ld_start_i;
    logic [ADDR_W-1:0] ld_base_i;
    logic              ld_byte_vld_i;
    logic [7:0]        ld_byte_i;
    logic              ld_byte_rdy_o;
    logic              ld_busy_o;
    logic [ADDR_W-1:0] ld_cnt_o;
    logic              rom_enb_o;
    logic [ADDR_W-1:0] rom_addrb_o;
    logic              rom_wen_o;
    logic [31:0]       rom_din_o;
    logic [31:0]       rom_doutb_i;

    modport slave (
        input  d_req_i, d_addr_i, ld_start_i, ld_base_i, ld_byte_vld_i, ld_byte_i, rom_doutb_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o, ld_byte_rdy_o, ld_busy_o, ld_cnt_o,
               rom_enb_o, rom_addrb_o, rom_wen_o, rom_din_o
    );

    modport master (
        output d_req_i, d_addr_i, ld_start_i, ld_base_i, ld_byte_vld_i, ld_byte_i, rom_doutb_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o, ld_byte_rdy_o, ld_busy_o, ld_cnt_o,
               rom_enb_o, rom_addrb_o, rom_wen_o, rom_din_o
    );
endinterface

// File: rtl/bootrom_port_arb.sv
// Shares bootrom port B between core data reads and a byte-stream loader (round-robin).
// Latency: grant is combinational; read data valid one cycle after grant.
// Backpressure: read req held until granted; loader rdy drops while a full word awaits write.
module bootrom_port_arb #(
    parameter int ADDR_W = 16
) (
    input logic                clk,
    input logic                rst,
    bootrom_port_arb_if.slave  bus
);
    typedef enum logic {
        L_COLLECT = 1'b0,
        L_WRITE   = 1'b1
    } ld_state_t;

    ld_state_t         state_q, state_d;
    logic [1:0]        byte_idx_q;
    logic [31:0]       word_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              last_wr_q;   // 1: last grant went to the loader write
    logic              rvalid_q;

    logic rd_req, wr_req, rd_gnt, wr_gnt;
    logic ld_rdy, byte_acc;

    // Requests and round-robin grant; start masks the loader write, reset masks everything.
    always_comb begin
        rd_req   = bus.d_req_i & ~rst;
        wr_req   = (state_q == L_WRITE) & ~bus.ld_start_i & ~rst;
        rd_gnt   = rd_req & (~wr_req | last_wr_q);
        wr_gnt   = wr_req & (~rd_req | ~last_wr_q);
        ld_rdy   = (state_q == L_COLLECT) & ~bus.ld_start_i & ~rst;
        byte_acc = bus.ld_byte_vld_i & ld_rdy;
    end

    // Loader next-state: collect four bytes, then hold until the write is granted.
    always_comb begin
        state_d = state_q;
        if (bus.ld_start_i) begin
            state_d = L_COLLECT;
        end else begin
            case (state_q)
                L_COLLECT: if (byte_acc && byte_idx_q == 2'd3) state_d = L_WRITE;
                L_WRITE:   if (wr_gnt) state_d = L_COLLECT;
                default:   state_d = L_COLLECT;
            endcase
        end
    end

    // Loader state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= L_COLLECT;
        else     state_q <= state_d;
    end

    // Word packing, write address / count, arbitration history and read-valid pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_q <= 2'd0;
            word_q     <= 32'd0;
            wr_addr_q  <= '0;
            cnt_q      <= '0;
            last_wr_q  <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            rvalid_q <= rd_gnt;
            if (rd_gnt || wr_gnt) last_wr_q <= wr_gnt;
            if (bus.ld_start_i) begin
                wr_addr_q  <= bus.ld_base_i;
                cnt_q      <= '0;
                byte_idx_q <= 2'd0;
            end else begin
                if (byte_acc) begin
                    word_q[{byte_idx_q, 3'b000} +: 8] <= bus.ld_byte_i;
                    byte_idx_q <= byte_idx_q + 2'd1;
                end
                if (wr_gnt) begin
                    wr_addr_q <= wr_addr_q + 1'b1;
                    cnt_q     <= cnt_q + 1'b1;
                end
            end
        end
    end

    // Output drive: port B follows the winner; everything forced low while in reset.
    always_comb begin
        bus.d_gnt_o       = rd_gnt;
        bus.d_rvalid_o    = rvalid_q & ~rst;
        bus.d_rdata_o     = (rvalid_q & ~rst) ? bus.rom_doutb_i : 32'd0;
        bus.ld_byte_rdy_o = ld_rdy;
        bus.ld_busy_o     = ~rst & ((byte_idx_q != 2'd0) | (state_q == L_WRITE));
        bus.ld_cnt_o      = rst ? '0 : cnt_q;
        bus.rom_enb_o     = 1'b0;
        bus.rom_wen_o     = 1'b0;
        bus.rom_addrb_o   = '0;
        bus.rom_din_o     = 32'd0;
        if (rd_gnt) begin
            bus.rom_enb_o   = 1'b1;
            bus.rom_addrb_o = bus.d_addr_i;
        end else if (wr_gnt) begin
            bus.rom_wen_o   = 1'b1;
            bus.rom_addrb_o = wr_addr_q;
            bus.rom_din_o   = word_q;
        end
    end
endmodule
